slot_crossbar: RTL

- Parametrised, slot-scheduled N×N crossbar; the next generation of the fixed 4-port crossbar.
- Sits between ingress VOQ readout and egress buffers.
- A schedule is latched at each slot boundary and held for SLOT_LEN words. Ingress words are then routed to egress ports with registered outputs.
- Adds per-ingress participation mask, deterministic conflict resolution, a sticky conflict flag, and a slot-boundary handshake.

---
 rtl/slot_crossbar.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/slot_crossbar.sv
// Slot-scheduled NxN crossbar with registered egress and sticky conflict flag.
// Define SLOT_CROSSBAR_OUT_PIPE_EN to add a second output register stage.
module slot_crossbar #(
  parameter int DATA_WIDTH = 32,
  parameter int PORT_CNT   = 4,
  parameter int SLOT_LEN   = 8,
  localparam int SW = $clog2(PORT_CNT),
  localparam int WW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SW*PORT_CNT-1:0]       sched_sel,
  input  logic [PORT_CNT-1:0]          sched_mask,
  input  logic                         sched_valid,
  output logic                         sched_ready,
  input  logic [PORT_CNT-1:0]          xbar_in_en,
  input  logic [DATA_WIDTH*PORT_CNT-1:0] xbar_in,
  output logic [PORT_CNT-1:0]          xbar_out_en,
  output logic [DATA_WIDTH*PORT_CNT-1:0] xbar_out,
  output logic                         slot_active,
  output logic [WW-1:0]                word_idx,
  output logic                         conflict,
  input  logic                         conflict_clr
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = DATA_WIDTH * PORT_CNT;
  localparam logic [WW-1:0] LAST = WW'(SLOT_LEN - 1);

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  state_t                 st_q, st_d;
  logic [WW-1:0]          idx_q, idx_d;
  logic [SW*PORT_CNT-1:0] sel_q, sel_d;
  logic [PORT_CNT-1:0]    mask_q, mask_d;
  logic                   conf_q, conf_d;
  logic                   accept;
  logic                   last;
  logic                   conf_in;
  logic                   hit;
  logic                   found;
  logic [PORT_CNT-1:0]    rt_en;
  logic [PW-1:0]          rt_dat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= IDLE;
      idx_q  <= '0;
      sel_q  <= '0;
      mask_q <= '0;
      conf_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      sel_q  <= sel_d;
      mask_q <= mask_d;
      conf_q <= conf_d;
    end
  end

  always_comb begin
    st_d        = st_q;
    idx_d       = idx_q;
    sel_d       = sel_q;
    mask_d      = mask_q;
    sched_ready = 1'b0;
    accept      = 1'b0;
    last        = (idx_q == LAST);
    unique case (st_q)
      IDLE: begin
        sched_ready = 1'b1;
        if (sched_valid) begin
          accept = 1'b1;
          st_d   = XFER;
          idx_d  = '0;
        end
      end
      XFER: begin
        sched_ready = last;
        if (!last) begin
          idx_d = idx_q + 1'b1;
        end else if (sched_valid) begin
          accept = 1'b1;
          idx_d  = '0;
        end else begin
          st_d  = IDLE;
          idx_d = '0;
        end
      end
    endcase
    if (accept) begin
      sel_d  = sched_sel;
      mask_d = sched_mask;
    end
    // a fresh conflict outranks a coincident clear
    conf_d = conf_q;
    if (accept && conf_in)
      conf_d = 1'b1;
    else if (conflict_clr)
      conf_d = 1'b0;
  end

  // out-of-range selects never equal a valid egress, so they drop out here
  always_comb begin
    conf_in = 1'b0;
    hit     = 1'b0;
    for (int e = 0; e < PORT_CNT; e++) begin
      hit = 1'b0;
      for (int i = 0; i < PORT_CNT; i++) begin
        if (sched_mask[i] && sched_sel[i*SW +: SW] == SW'(e)) begin
          if (hit)
            conf_in = 1'b1;
          hit = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rt_en  = '0;
    rt_dat = '0;
    found  = 1'b0;
    if (st_q == XFER) begin
      for (int e = 0; e < PORT_CNT; e++) begin
        found = 1'b0;
        for (int i = 0; i < PORT_CNT; i++) begin
          if (!found && mask_q[i] && sel_q[i*SW +: SW] == SW'(e)) begin
            found                = 1'b1;
            rt_en[e]             = xbar_in_en[i];
            rt_dat[e*DW +: DW]   = xbar_in[i*DW +: DW];
          end
        end
      end
    end
  end

`ifdef SLOT_CROSSBAR_OUT_PIPE_EN
  logic [PORT_CNT-1:0] p_en;
  logic [PW-1:0]       p_dat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_en        <= '0;
      p_dat       <= '0;
      xbar_out_en <= '0;
      xbar_out    <= '0;
    end else begin
      p_en        <= rt_en;
      p_dat       <= rt_dat;
      xbar_out_en <= p_en;
      xbar_out    <= p_dat;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xbar_out_en <= '0;
      xbar_out    <= '0;
    end else begin
      xbar_out_en <= rt_en;
      xbar_out    <= rt_dat;
    end
  end
`endif

  assign slot_active = (st_q == XFER);
  assign word_idx    = idx_q;
  assign conflict    = conf_q;

endmodule
